// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: drives the J/K inputs of a WIDTH-bit JK flip-flop bank to load/clear/set/toggle/count it.
// Latency: accept edge -> 1 EXEC cycle (N for UP/DOWN, none when N=0) -> 1 DONE cycle -> IDLE.
// Backpressure: cmd_ready is high only in IDLE; commands offered at any other time are ignored.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNTW-1:0]  cmd_arg,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_SET  = 3'b011;
  localparam logic [2:0] OP_UP   = 3'b100;
  localparam logic [2:0] OP_DOWN = 3'b101;
  localparam logic [2:0] OP_TGL  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             is_count;
  logic [WIDTH-1:0] up_t, dn_t;

  assign is_count = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

  // State and latched-command registers; Clear aborts any command immediately.
  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      arg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: q_fb is deliberately absent so unknown feedback cannot disturb control.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          arg_d   = cmd_arg[WIDTH-1:0];
          cnt_d   = is_count ? cmd_arg : CNTW'(1);
          state_d = (is_count && (cmd_arg == '0)) ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counting toggle enables: bit i flips when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic up_acc;
    logic dn_acc;
    up_acc = 1'b1;
    dn_acc = 1'b1;
    up_t   = '0;
    dn_t   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_acc;
      dn_t[i] = dn_acc;
      up_acc  = up_acc & q_fb[i];
      dn_acc  = dn_acc & ~q_fb[i];
    end
  end

  // Outputs: J/K only driven in EXEC so the bank updates on the same edge the counter steps.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q == S_EXEC);
    done      = (state_q == S_DONE);
    j_out     = '0;
    k_out     = '0;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_LOAD: begin
          j_out = arg_q;
          k_out = ~arg_q;
        end
        OP_CLR:  k_out = '1;
        OP_SET:  j_out = '1;
        OP_UP: begin
          j_out = up_t;
          k_out = up_t;
        end
        OP_DOWN: begin
          j_out = dn_t;
          k_out = dn_t;
        end
        OP_TGL: begin
          j_out = arg_q;
          k_out = arg_q;
        end
        default: begin
          j_out = '0;
          k_out = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: directed bench with a behavioural JK bank and a result scoreboard.
// Expected final Q and EXEC-cycle count are queued at issue and popped on the done pulse.
// All DUT outputs are sampled on the falling clock edge.
module tb_jk_bank_sequencer;
  localparam int WIDTH = 4;
  localparam int CNTW  = 8;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_SET  = 3'b011;
  localparam logic [2:0] OP_UP   = 3'b100;
  localparam logic [2:0] OP_DOWN = 3'b101;
  localparam logic [2:0] OP_TGL  = 3'b110;

  logic             clk = 1'b0;
  logic             Clear;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNTW-1:0]  cmd_arg;
  logic [WIDTH-1:0] q_bank;
  logic [WIDTH-1:0] j_out, k_out;
  logic             busy, done;
  logic             bank_ld;
  logic [WIDTH-1:0] bank_val;

  int n_pass  = 0;
  int n_total = 0;

  logic [WIDTH-1:0] sb_q[$];
  int               sb_exec[$];

  always #5 clk = ~clk;

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .Clear     (Clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .q_fb      (q_bank),
    .j_out     (j_out),
    .k_out     (k_out),
    .busy      (busy),
    .done      (done)
  );

  // Behavioural JK bank; bank_ld stands in for its system-controlled preset/clear pins.
  always @(posedge clk) begin
    if (bank_ld) q_bank <= bank_val;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_out[i], k_out[i]})
          2'b10:   q_bank[i] <= 1'b1;
          2'b01:   q_bank[i] <= 1'b0;
          2'b11:   q_bank[i] <= ~q_bank[i];
          default: q_bank[i] <= q_bank[i];
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic preload(input logic [WIDTH-1:0] v);
    bank_ld  = 1'b1;
    bank_val = v;
    @(negedge clk);
    bank_ld  = 1'b0;
  endtask

  // Issue one command from IDLE, follow it to completion, score it, and return in IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [CNTW-1:0] arg,
                         input logic [WIDTH-1:0] exp_final, input int exp_exec,
                         input bit intrude);
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] pop_q;
    int               pop_e;
    int               n;
    bit               seen;
    check("ready_before_cmd", cmd_ready, 1'b1);
    start = q_bank;
    m     = arg[WIDTH-1:0];
    sb_q.push_back(exp_final);
    sb_exec.push_back(exp_exec);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) begin
          case (op)
            OP_UP:   check("step_q_up", q_bank, WIDTH'(start + WIDTH'(n)));
            OP_DOWN: check("step_q_down", q_bank, WIDTH'(start - WIDTH'(n)));
            default: check("step_q", q_bank, start);
          endcase
          case (op)
            OP_LOAD: check("load_jk", {j_out, k_out}, {m, ~m});
            OP_CLR:  check("clr_jk", {j_out, k_out}, {4'b0000, 4'b1111});
            OP_SET:  check("set_jk", {j_out, k_out}, {4'b1111, 4'b0000});
            OP_TGL:  check("tgl_jk", {j_out, k_out}, {m, m});
            default: ;
          endcase
          if (intrude) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_SET;
            cmd_arg   = 8'hFF;
            check("ready_while_busy", cmd_ready, 1'b0);
          end
          n++;
        end
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    check("done_seen", seen, 1'b1);
    pop_q = sb_q.pop_front();
    pop_e = sb_exec.pop_front();
    check("exec_cycles", n, pop_e);
    check("final_q", q_bank, pop_q);
    check("done_jk_zero", {j_out, k_out}, 0);
    check("done_not_busy", busy, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("ready_after", cmd_ready, 1'b1);
  endtask

  initial begin
    Clear     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    cmd_arg   = 8'hFF;
    bank_ld   = 1'b1;
    bank_val  = '0;

    // Reset held with a command offered: nothing must be accepted.
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_jk", {j_out, k_out}, 0);
    end
    cmd_valid = 1'b0;
    bank_ld   = 1'b0;
    Clear     = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_q", q_bank, 4'b0000);

    run_cmd(OP_LOAD, 8'h0A, 4'b1010, 1, 1'b0);
    run_cmd(OP_SET,  8'h00, 4'b1111, 1, 1'b0);
    run_cmd(OP_CLR,  8'h00, 4'b0000, 1, 1'b0);

    preload(4'b1101);
    run_cmd(OP_UP, 8'd5, 4'b0010, 5, 1'b0);

    preload(4'b0001);
    run_cmd(OP_DOWN, 8'd3, 4'b1110, 3, 1'b0);
    run_cmd(OP_UP,   8'd0, 4'b1110, 0, 1'b0);

    preload(4'b1010);
    run_cmd(OP_TGL, 8'h06, 4'b1100, 1, 1'b1);

    // Abort an UP-by-10 after four steps.
    preload(4'b0000);
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_arg   = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pre_busy", busy, 1'b1);
    check("abort_pre_q", q_bank, 4'b0100);
    Clear = 1'b0;
    #1;
    check("abort_jk_zero", {j_out, k_out}, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_done", done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    check("abort_q_hold", q_bank, 4'b0100);
    Clear = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", busy, 1'b0);
    check("abort_idle_done", done, 1'b0);
    check("abort_q_after", q_bank, 4'b0100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
